// File: rtl/draw_cmd_fifo.sv
// Draw-command queue between the memory controller and the draw unit. First-word-fall-through, latency 1 from push to outValid.
// Producer stalls on full; a push while full is dropped and flagged in sticky overflow. Consumer pops with outValid & outReady.
module draw_cmd_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [WIDTH-1:0] dataIn,
  output logic             full,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] dataOut,
  output logic [AW:0]      count,
  output logic             overflow,
  input  logic             clrOvf
);

  localparam logic [AW:0] CountMax = (AW+1)'(DEPTH);
  localparam logic [AW:0] CountOne = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             push;
  logic             pop;
  logic             drop;

  // Flags come only from the registered count so the memory controller's stall never loops through we.
  assign full     = (count == CountMax);
  assign outValid = (count != '0);
  assign push     = we & ~full;
  assign drop     = we & full;
  assign pop      = outValid & outReady;
  assign dataOut  = mem[rp];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp] <= dataIn;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wp <= wp + AW'(1);
      end
      if (pop) begin
        rp <= rp + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CountOne;
      end else if (pop && !push) begin
        count <= count - CountOne;
      end
      // A drop on the same edge as a clear must stay visible.
      if (drop) begin
        overflow <= 1'b1;
      end else if (clrOvf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_draw_cmd_fifo.sv
// Directed bench for draw_cmd_fifo: stimulus queues expected words, a negedge monitor checks every pop.
module tb_draw_cmd_fifo;
  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             we;
  logic [WIDTH-1:0] dataIn;
  logic             full;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] dataOut;
  logic [AW:0]      count;
  logic             overflow;
  logic             clrOvf;

  int checks = 0;
  int errors = 0;
  int mCount = 0;
  logic [WIDTH-1:0] expQ [$];

  draw_cmd_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .we(we), .dataIn(dataIn), .full(full),
    .outValid(outValid), .outReady(outReady), .dataOut(dataOut),
    .count(count), .overflow(overflow), .clrOvf(clrOvf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: a word is consumed on the next edge whenever outValid & outReady.
  always @(negedge clk) begin
    if (outValid === 1'b1 && outReady === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected actual=%0h required=none", dataOut);
      end else begin
        chk("pop_data", 32'(dataOut), 32'(expQ.pop_front()));
      end
    end
  end

  // One clock cycle of stimulus; inputs change 1 time unit after the rising edge.
  task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic r, input logic c);
    bit acc;
    bit popd;
    we = w; dataIn = d; outReady = r; clrOvf = c;
    acc  = w && (mCount != DEPTH);
    popd = r && (mCount != 0);
    if (acc) expQ.push_back(d);
    mCount = mCount + (acc ? 1 : 0) - (popd ? 1 : 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; we = 1'b0; dataIn = '0; outReady = 1'b0; clrOvf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(outValid), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    reset = 1'b1;

    // single word through an empty queue
    step(1'b1, 16'h1234, 1'b0, 1'b0);
    chk("one_valid", 32'(outValid), 1);
    chk("one_data", 32'(dataOut), 32'h1234);
    chk("one_count", 32'(count), 1);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("one_pop_valid", 32'(outValid), 0);
    chk("one_pop_count", 32'(count), 0);

    // fill, overflow, drain in order, clear
    for (int i = 0; i < 16; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), 16);
    chk("fill_ovf", 32'(overflow), 0);
    step(1'b1, 16'hBEEF, 1'b0, 1'b0);
    chk("drop_ovf", 32'(overflow), 1);
    chk("drop_count", 32'(count), 16);
    for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1, 1'b0);
    chk("drain_count", 32'(count), 0);
    chk("drain_valid", 32'(outValid), 0);
    chk("drain_ovf_sticky", 32'(overflow), 1);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("clr_ovf", 32'(overflow), 0);

    // full with push and pop together: pop happens, push dropped
    for (int i = 0; i < 16; i++) step(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0);
    step(1'b1, 16'hDEAD, 1'b1, 1'b0);
    chk("fullpp_count", 32'(count), 15);
    chk("fullpp_ovf", 32'(overflow), 1);
    chk("fullpp_full", 32'(full), 0);
    step(1'b1, 16'h0200, 1'b0, 1'b0);
    chk("refill_count", 32'(count), 16);
    step(1'b1, 16'h0BAD, 1'b0, 1'b1);
    chk("clr_vs_drop_ovf", 32'(overflow), 1);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("clr2_ovf", 32'(overflow), 0);
    for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1, 1'b0);
    chk("drain2_count", 32'(count), 0);

    // empty with push and pop: push only
    step(1'b1, 16'h0055, 1'b1, 1'b0);
    chk("emptypp_count", 32'(count), 1);
    step(1'b0, '0, 1'b1, 1'b0);

    // steady streaming at half full across pointer wrap
    for (int i = 0; i < 8; i++) step(1'b1, 16'(16'h0300 + i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 16'(16'h0400 + i), 1'b1, 1'b0);
      chk("stream_count", 32'(count), 8);
    end
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);
    chk("stream_drain", 32'(count), 0);

    // asynchronous reset mid-stream with count 7 and overflow set
    for (int i = 0; i < 16; i++) step(1'b1, 16'(16'h0500 + i), 1'b0, 1'b0);
    step(1'b1, 16'hFFFF, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, '0, 1'b1, 1'b0);
    chk("pre_rst_count", 32'(count), 7);
    chk("pre_rst_ovf", 32'(overflow), 1);
    outReady = 1'b0;
    #2;
    reset = 1'b0;
    expQ.delete();
    mCount = 0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_valid", 32'(outValid), 0);
    chk("arst_full", 32'(full), 0);
    chk("arst_ovf", 32'(overflow), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(1'b1, 16'h0077, 1'b0, 1'b0);
    chk("post_rst_count", 32'(count), 1);
    chk("post_rst_data", 32'(dataOut), 32'h0077);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("end_count", 32'(count), 0);
    chk("leftover", 32'(expQ.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/draw_cmd_fifo.md
DRAW_CMD_FIFO -- requirements
Module: draw_cmd_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the command word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, the number of entries; legal values are powers of two from 4 to 64.
REQ-003 SHALL have parameter AW, default 4, the pointer width; AW = log2(DEPTH).
REQ-004 SHALL have port clk  input  1  system clock (50 MHz); all state changes on the rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port we  input  1  push request from the memory controller's pixel-RAM write strobe.
REQ-007 SHALL have port dataIn  input  WIDTH  command word to push.
REQ-008 SHALL have port full  output  1  high when count == DEPTH; the memory controller stalls on this.
REQ-009 SHALL have port outValid  output  1  high when count != 0.
REQ-010 SHALL have port outReady  input  1  the draw unit consumes the head word this cycle.
REQ-011 SHALL have port dataOut  output  WIDTH  head-of-queue word, first-word-fall-through.
REQ-012 SHALL have port count  output  AW+1  number of words stored.
REQ-013 SHALL have port overflow  output  1  sticky flag: a push was dropped.
REQ-014 SHALL have port clrOvf  input  1  synchronous clear of overflow.

Function
REQ-015 SHALL store words in a DEPTH x WIDTH array, with write pointer wp and read pointer rp, each AW bits, both wrapping modulo DEPTH.
REQ-016 SHALL accept a push (write mem[wp], wp+1) iff we=1 and full=0 at the clock edge.
REQ-017 SHALL perform a pop (rp+1) iff outValid=1 and outReady=1 at the clock edge; outReady with outValid=0 SHALL have no effect.
REQ-018 SHALL update count as +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop.
REQ-019 SHALL derive full and outValid from the registered count, never from the same-cycle we or outReady.
REQ-020 SHALL, when full, drop a push even if a pop occurs in the same cycle, and set overflow on that edge.
REQ-021 SHALL, when empty and pushed, raise outValid one cycle later with dataOut equal to the pushed word (latency 1).
REQ-022 SHALL, when empty, ignore a simultaneous push and pop request: the push is accepted, no pop occurs, and count becomes 1.
REQ-023 SHALL drive dataOut = mem[rp] combinationally from storage; its value is don't-care while outValid=0.
REQ-024 SHALL present words on dataOut in strict push order, with no loss except drops flagged per REQ-020.
REQ-025 SHALL set overflow to 1 on any dropped push and hold it until clrOvf=1; a drop on the same edge as clrOvf SHALL leave overflow at 1 (set wins).
REQ-026 SHALL keep count within 0..DEPTH at all times.

Reset
REQ-027 SHALL, while reset=0, immediately force wp=0, rp=0, count=0, full=0, outValid=0, and overflow=0, independent of clk.
REQ-028 SHALL discard all queued contents on reset asserted mid-operation; array contents need not be cleared.
REQ-029 SHALL ignore pushes and pops on the first edge after reset deasserts only if they arrive with reset still low; normal operation SHALL resume on the next edge.

Verification
REQ-030 SHALL cover: push 0x1234 into an empty FIFO -> next cycle outValid=1, dataOut=0x1234, count=1; pop -> outValid=0, count=0.
REQ-031 SHALL cover: 16 pushes of 0x0000..0x000F with outReady=0 -> full=1, count=16; a 17th push of 0xBEEF -> overflow=1, count=16; draining yields 0x0000..0x000F in order.
REQ-032 SHALL cover: full FIFO with we=1 and outReady=1 together -> count=15, push dropped, overflow=1.
REQ-033 SHALL cover: continuous push and pop at half-full for 40 cycles (pointer wrap) -> count stays constant and the output sequence equals the input sequence.
REQ-034 SHALL cover: reset pulsed low mid-stream with count=7 -> count=0, outValid=0, full=0, and overflow=0 immediately, without waiting for a clock edge.
REQ-035 SHALL cover: overflow=1 then clrOvf=1 -> overflow=0 next edge; clrOvf=1 coinciding with a dropped push -> overflow stays 1.
